// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and helpers for the serial magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 2;

    // Slice-counter width: clog2(width/2), never narrower than one bit.
    function automatic int cnt_width(input int width);
        int nsl;
        int w;
        nsl = width / SLICE_W;
        w   = 0;
        while ((1 << w) < nsl) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cmp_slice2.sv
// rtl/cmp_slice2.sv - combinational 2-bit slice comparator (one-hot eq/gt/lt)
module cmp_slice2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_seq_serial.sv
// rtl/cmp_seq_serial.sv - MSB-first serial magnitude comparator; CMP_SIGNED_EN selects two's complement operands
module cmp_seq_serial
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             more,
    output logic             less
);

    localparam int NSL   = WIDTH / SLICE_W;
    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               eq_q, eq_d;
    logic               more_q, more_d;
    logic               less_q, less_d;
    logic [WIDTH-1:0]   a_cap, b_cap;
    logic               sl_eq, sl_gt, sl_lt;

`ifdef CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign a_cap = {~A[WIDTH-1], A[WIDTH-2:0]};
    assign b_cap = {~B[WIDTH-1], B[WIDTH-2:0]};
`else
    assign a_cap = A;
    assign b_cap = B;
`endif

    cmp_slice2 u_slice (
        .a  (a_q[WIDTH-1 -: SLICE_W]),
        .b  (b_q[WIDTH-1 -: SLICE_W]),
        .eq (sl_eq),
        .gt (sl_gt),
        .lt (sl_lt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        more_d  = more_q;
        less_d  = less_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_cap;
                    b_d     = b_cap;
                    cnt_d   = CNT_W'(NSL - 1);
                    eq_d    = 1'b0;
                    more_d  = 1'b0;
                    less_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!sl_eq) begin
                    more_d  = sl_gt;
                    less_d  = sl_lt;
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    a_d   = a_q << SLICE_W;
                    b_d   = b_q << SLICE_W;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            more_q  <= 1'b0;
            less_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            more_q  <= more_d;
            less_q  <= less_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign equal = eq_q;
    assign more  = more_q;
    assign less  = less_q;

endmodule

// File: tb/tb_cmp_seq_serial.sv
// tb/tb_cmp_seq_serial.sv - scoreboard bench for cmp_seq_serial (WIDTH=8)
module tb_cmp_seq_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic       equal;
    logic       more;
    logic       less;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0] flags;
        int         cycle;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    cmp_seq_serial #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .equal (equal),
        .more  (more),
        .less  (less)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cycle=%0d flags=%b required=no done", cyc, {equal, more, less});
            end else begin
                e = exp_q.pop_front();
                if ({equal, more, less} !== e.flags) begin
                    errors++;
                    $display("FAIL done_flags got=%b required=%b", {equal, more, less}, e.flags);
                end
                checks++;
                if (cyc != e.cycle) begin
                    errors++;
                    $display("FAIL done_cycle got=%0d required=%0d", cyc, e.cycle);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Accept a start in cycle 0; returns at the negedge of cycle 1.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] flags, input int lat, input bit track);
        exp_t e;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        if (track) begin
            e.flags = flags;
            e.cycle = cyc + lat + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        check("flags_clear_after_start", {29'd0, equal, more, less}, 32'd0);
        check("busy_cycle1", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A = 8'h00;
        B = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", {27'd0, busy, done, equal, more, less}, 32'd0);
        rst_n = 1'b1;

        // MSB-slice mismatch
        issue(8'hC0, 8'h40, F_GT, 1, 1'b1);
        drain();
        issue(8'h40, 8'hC0, F_LT, 1, 1'b1);
        drain();

        // full equality, worst-case latency; busy over cycles 1..5
        issue(8'h5A, 8'h5A, F_EQ, 4, 1'b1);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            check("busy_window", {31'd0, busy}, (k <= 5) ? 32'd1 : 32'd0);
        end
        drain();

        // LSB-slice difference, then flags hold while idle
        issue(8'h03, 8'h02, F_GT, 4, 1'b1);
        drain();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("flags_hold_idle", {29'd0, equal, more, less}, {29'd0, F_GT});
        end

        // start while busy is ignored
        issue(8'h03, 8'h02, F_GT, 4, 1'b1);
        @(negedge clk);
        A = 8'h00;
        B = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // reset mid-RUN discards the compare
        issue(8'hF0, 8'hF1, F_LT, 4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_run", {27'd0, busy, done, equal, more, less}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'hF0, 8'hF1, F_LT, 4, 1'b1);
        drain();

        // start held high: accepted again in the IDLE cycle after DONE
        begin
            exp_t e;
            @(negedge clk);
            A = 8'hC0;
            B = 8'h40;
            start = 1'b1;
            e.flags = F_GT;
            e.cycle = cyc + 2;
            exp_q.push_back(e);
            e.cycle = cyc + 5;
            exp_q.push_back(e);
            repeat (5) @(negedge clk);
            start = 1'b0;
            drain();
        end

        // sign handling
`ifdef CMP_SIGNED_EN
        issue(8'h80, 8'h01, F_LT, 1, 1'b1);
`else
        issue(8'h80, 8'h01, F_GT, 1, 1'b1);
`endif
        drain();
        issue(8'hFF, 8'hFE, F_GT, 4, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
